axi_ram_slave: RTL
==================

# axi_ram_slave

AXI3 slave memory (responder side) for the CPU's 32-bit AXI master port; services the read channel (AR/R) and write channel (AW/W/B) independently out of one word-addressed RAM array. Serves as the instruction/data memory behind the CPU top in simulation and small FPGA builds, replacing the SRAM-style hookup. Supports FIXED/INCR/WRAP bursts of 1–16 beats, one outstanding read and one outstanding write.

## Interface
- ADDR_W, 12, word-address bits; array holds 2^ADDR_W 32-bit words; byte address bits [ADDR_W+1:2] index it, higher bits ignored (aliasing)
- ID_W, 4, width of all ID fields
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-high; one clock, synchronous active-high reset (fixed decision)
- arid/araddr/arlen/arsize/arburst  in  ID_W/32/4/3/2  read address; arlock/arcache/arprot accepted and ignored
- arvalid in 1; arready out 1
- rid/rdata/rresp/rlast/rvalid  out  ID_W/32/2/1/1; rready in 1
- awid/awaddr/awlen/awsize/awburst  in  ID_W/32/4/3/2; awlock/awcache/awprot ignored
- awvalid in 1; awready out 1
- wid/wdata/wstrb/wlast/wvalid  in  ID_W/32/4/1/1 (wid ignored); wready out 1
- bid/bresp/bvalid  out  ID_W/2/1; bready in 1

## Operation
- Read FSM R_IDLE → R_DATA. arready = R_IDLE and not reset. AR handshake latches id, addr, len, size, burst; beat counter = 0; rdata register loaded with mem[addr]; go R_DATA.
- R_DATA: rvalid=1, rid=latched id, rresp=00, rlast = (beat==len). On R handshake: if rlast → R_IDLE; else addr = next(addr), beat+1, rdata reloaded from mem[next] same edge. rdata/rvalid/rlast stable while rready=0.
- Write FSM W_IDLE → W_DATA → W_RESP. awready = W_IDLE and not reset; wready = W_DATA. W beats arriving before AW stall (wready=0).
- W_DATA: each W handshake writes bytes of mem[addr] with wstrb[i]=1 (byte i = wdata[8i+7:8i]), then addr = next(addr), beat+1. Burst ends on beat == awlen regardless of wlast → W_RESP.
- wlast mismatch (wlast=1 before final beat, or 0 on final beat) sets sticky error; bresp = 10 (SLVERR) instead of 00. Data still written for every beat.
- W_RESP: bvalid=1, bid=latched awid; on bready → W_IDLE.
- next(addr): inc = 1<<size (size>2 treated as 2). FIXED(00): unchanged. INCR(01)/reserved(11): addr+inc. WRAP(10), len∈{1,3,7,15}: addr+inc wrapped within aligned (len+1)*inc region; other len treated as INCR.
- Arithmetic 32-bit, carry-out discarded; index from low bits, so incrementing past top of array wraps to word 0.

## Timing
- Reset (cycle reset high and after): arready=awready=wready=rvalid=rlast=bvalid=0, rid=bid=0, rdata=0, rresp=bresp=00; both FSMs idle; array contents preserved. Reset mid-burst abandons the burst; no further R/B beats.
- Read: AR handshake at edge T → rvalid=1 with beat 0 in cycle T+1. Back-to-back beats 1/cycle with rready held high; len=L burst completes at edge T+1+L; arready returns next cycle (1 idle cycle between bursts).
- Write: AW at edge T → wready=1 from T+1; one beat/cycle; final W handshake at edge E → bvalid from E+1; awready from cycle after B handshake.
- Channels fully concurrent. Same-word write and read-load on same edge: read register captures pre-write data.
- AR and AW never accepted while respective FSM busy; no interleaving or reordering.

## Test plan
- Reset then single read: write 0x1fc00000←0xDEADBEEF (awlen 0, wstrb F) → bresp 00; read same addr arlen 0 → rdata 0xDEADBEEF, rlast=1, rid=arid, rvalid at T+1.
- INCR read arlen=3 at 0x100, rready toggled 1,0,1,1,0,1 → four beats mem[0x100..0x10C] in order, each held stable during stall, rlast only on 4th.
- WRAP read arlen=3 from 0x108 → addresses 0x108, 0x10C, 0x100, 0x104.
- Byte strobes: word 0x11223344, write 0xAABBCCDD wstrb 0101 → readback 0x11BB33DD.
- wlast asserted on beat 1 of awlen=3 → all 4 beats written, bresp=10; bvalid held until bready=1 three cycles later.
- Concurrent 16-beat read and 16-beat write on disjoint ranges, then assert reset mid-read → rvalid=0 next cycle, arready=1 after release, prior written data intact.

Source files
------------

// File: rtl/axi_ram_slave.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// axi_ram_slave
//
// AXI3 responder backed by a single word-addressed RAM of 2^ADDR_W 32-bit
// words. The read channel (AR/R) and write channel (AW/W/B) run as two fully
// independent state machines, each with one burst outstanding. FIXED, INCR
// and WRAP bursts of 1-16 beats are supported; byte address bits
// [ADDR_W+1:2] select the word, so higher address bits alias.
//
// Ports
//   clk, reset                     rising-edge clock, synchronous active-high reset
//   ar*  (id/addr/len/size/burst)  read address channel; lock/cache/prot ignored
//   r*   (id/data/resp/last)       read data channel, rresp always OKAY
//   aw*  (id/addr/len/size/burst)  write address channel; lock/cache/prot ignored
//   w*   (data/strb/last)          write data channel; wid ignored
//   b*   (id/resp)                 write response; SLVERR if wlast was misplaced
// ---------------------------------------------------------------------------
module axi_ram_slave #(
    parameter int ADDR_W = 12,
    parameter int ID_W   = 4
) (
    input  logic              clk,
    input  logic              reset,

    input  logic [ID_W-1:0]   arid,
    input  logic [31:0]       araddr,
    input  logic [3:0]        arlen,
    input  logic [2:0]        arsize,
    input  logic [1:0]        arburst,
    input  logic [1:0]        arlock,
    input  logic [3:0]        arcache,
    input  logic [2:0]        arprot,
    input  logic              arvalid,
    output logic              arready,

    output logic [ID_W-1:0]   rid,
    output logic [31:0]       rdata,
    output logic [1:0]        rresp,
    output logic              rlast,
    output logic              rvalid,
    input  logic              rready,

    input  logic [ID_W-1:0]   awid,
    input  logic [31:0]       awaddr,
    input  logic [3:0]        awlen,
    input  logic [2:0]        awsize,
    input  logic [1:0]        awburst,
    input  logic [1:0]        awlock,
    input  logic [3:0]        awcache,
    input  logic [2:0]        awprot,
    input  logic              awvalid,
    output logic              awready,

    input  logic [ID_W-1:0]   wid,
    input  logic [31:0]       wdata,
    input  logic [3:0]        wstrb,
    input  logic              wlast,
    input  logic              wvalid,
    output logic              wready,

    output logic [ID_W-1:0]   bid,
    output logic [1:0]        bresp,
    output logic              bvalid,
    input  logic              bready
);

    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic [0:0] {R_IDLE, R_DATA} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

    logic [31:0] mem [DEPTH];

    // Address of the beat after 'addr'. Sizes above 4 bytes are clamped to
    // the 32-bit bus width. WRAP only wraps for legal lengths (2/4/8/16 beats);
    // anything else falls back to INCR behaviour.
    function automatic logic [31:0] next_addr(input logic [31:0] addr,
                                              input logic [2:0]  size,
                                              input logic [3:0]  len,
                                              input logic [1:0]  burst);
        logic [31:0] inc;
        logic [31:0] sum;
        logic [31:0] mask;
        inc  = (size > 3'd2) ? 32'd4 : (32'd1 << size);
        sum  = addr + inc;
        mask = (({28'd0, len} + 32'd1) * inc) - 32'd1;
        case (burst)
            2'b00:   next_addr = addr;
            2'b10: begin
                if (len == 4'd1 || len == 4'd3 || len == 4'd7 || len == 4'd15)
                    next_addr = (addr & ~mask) | (sum & mask);
                else
                    next_addr = sum;
            end
            default: next_addr = sum;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Read channel
    // ------------------------------------------------------------------
    r_state_t    r_state, r_state_next;
    logic [31:0] r_addr;
    logic [3:0]  r_len;
    logic [2:0]  r_size;
    logic [1:0]  r_burst;
    logic [3:0]  r_beat;
    logic [31:0] r_next;
    logic        ar_hs;
    logic        r_hs;

    assign r_next = next_addr(r_addr, r_size, r_len, r_burst);
    assign ar_hs  = arvalid && arready;
    assign r_hs   = rvalid && rready;
    assign rresp  = 2'b00;

    always_ff @(posedge clk) begin
        if (reset)
            r_state <= R_IDLE;
        else
            r_state <= r_state_next;
    end

    always_comb begin
        r_state_next = r_state;
        arready      = 1'b0;
        rvalid       = 1'b0;
        rlast        = 1'b0;
        case (r_state)
            R_IDLE: begin
                arready = !reset;
                if (arvalid && !reset)
                    r_state_next = R_DATA;
            end
            R_DATA: begin
                rvalid = !reset;
                rlast  = !reset && (r_beat == r_len);
                if (rready && r_beat == r_len)
                    r_state_next = R_IDLE;
            end
            default: r_state_next = R_IDLE;
        endcase
    end

    // rdata is a register so it holds steady while the master stalls; it is
    // refilled from the next word on the same edge that retires a beat.
    always_ff @(posedge clk) begin
        if (reset) begin
            rid   <= '0;
            rdata <= '0;
        end else if (ar_hs) begin
            rid   <= arid;
            rdata <= mem[araddr[ADDR_W+1:2]];
        end else if (r_hs && !rlast) begin
            rdata <= mem[r_next[ADDR_W+1:2]];
        end
    end

    always_ff @(posedge clk) begin
        if (ar_hs) begin
            r_addr  <= araddr;
            r_len   <= arlen;
            r_size  <= arsize;
            r_burst <= arburst;
            r_beat  <= 4'd0;
        end else if (r_hs && !rlast) begin
            r_addr  <= r_next;
            r_beat  <= r_beat + 4'd1;
        end
    end

    // ------------------------------------------------------------------
    // Write channel
    // ------------------------------------------------------------------
    w_state_t    w_state, w_state_next;
    logic [31:0] w_addr;
    logic [3:0]  w_len;
    logic [2:0]  w_size;
    logic [1:0]  w_burst;
    logic [3:0]  w_beat;
    logic        w_err;
    logic        w_last_beat;
    logic        aw_hs;
    logic        w_hs;

    assign w_last_beat = (w_beat == w_len);
    assign aw_hs       = awvalid && awready;
    assign w_hs        = wvalid && wready;

    always_ff @(posedge clk) begin
        if (reset)
            w_state <= W_IDLE;
        else
            w_state <= w_state_next;
    end

    // The burst length comes from awlen alone; wlast is only checked.
    always_comb begin
        w_state_next = w_state;
        awready      = 1'b0;
        wready       = 1'b0;
        bvalid       = 1'b0;
        case (w_state)
            W_IDLE: begin
                awready = !reset;
                if (awvalid && !reset)
                    w_state_next = W_DATA;
            end
            W_DATA: begin
                wready = !reset;
                if (wvalid && !reset && w_last_beat)
                    w_state_next = W_RESP;
            end
            W_RESP: begin
                bvalid = !reset;
                if (bready)
                    w_state_next = W_IDLE;
            end
            default: w_state_next = W_IDLE;
        endcase
    end

    assign bresp = bvalid ? {w_err, 1'b0} : 2'b00;

    always_ff @(posedge clk) begin
        if (reset) begin
            bid   <= '0;
            w_err <= 1'b0;
        end else if (aw_hs) begin
            bid   <= awid;
            w_err <= 1'b0;
        end else if (w_hs && (wlast != w_last_beat)) begin
            w_err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (aw_hs) begin
            w_addr  <= awaddr;
            w_len   <= awlen;
            w_size  <= awsize;
            w_burst <= awburst;
            w_beat  <= 4'd0;
        end else if (w_hs) begin
            w_addr  <= next_addr(w_addr, w_size, w_len, w_burst);
            w_beat  <= w_beat + 4'd1;
        end
    end

    // Nonblocking write: a read load of the same word on this edge sees
    // the old contents.
    always_ff @(posedge clk) begin
        if (w_hs) begin
            for (int i = 0; i < 4; i++) begin
                if (wstrb[i])
                    mem[w_addr[ADDR_W+1:2]][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    logic unused_ok;
    assign unused_ok = ^{arlock, arcache, arprot, awlock, awcache, awprot, wid};

endmodule
